// File: rtl/ram_1port_arb.sv
// ram_1port_arb
//    Arbitrates two clients (A and B) onto one single-port RAM.
//    Grants are combinational (Ack in the cycle the request is seen), the RAM
//    command is registered, and the read return is steered back to whichever
//    client issued the read using an owner tag that travels with the command.
//
//    Pipeline, ack in cycle C:
//       C   : o_X_Ack high, request consumed at the closing edge
//       C+1 : o_RAM_Wr_DV or o_RAM_Rd_En high with address / write data
//       C+2 : i_RAM_Rd_DV from the RAM (fixed one-cycle read latency)
//       C+3 : o_X_Rd_DV pulse with o_X_Rd_Data
//
//    Configuration macro:
//       RAM_ARB_FIXED_PRIO_EN  defined   -> A always wins contention
//                              undefined -> round-robin, last grantee loses ties
//
// Ports
//    i_Clk, i_Rst_L                 clock, synchronous active-low reset
//    i_X_Req/Wr/Addr/Wr_Data        client X request (X = A, B), held until acked
//    o_X_Ack                        combinational grant
//    o_X_Rd_DV, o_X_Rd_Data         registered read return to client X
//    o_RAM_Addr/Wr_DV/Wr_Data/Rd_En registered RAM command
//    i_RAM_Rd_DV, i_RAM_Rd_Data     RAM read return
module ram_1port_arb #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 256,
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             i_Clk,
   input  logic             i_Rst_L,
   input  logic             i_A_Req,
   input  logic             i_A_Wr,
   input  logic [AW-1:0]    i_A_Addr,
   input  logic [WIDTH-1:0] i_A_Wr_Data,
   output logic             o_A_Ack,
   output logic             o_A_Rd_DV,
   output logic [WIDTH-1:0] o_A_Rd_Data,
   input  logic             i_B_Req,
   input  logic             i_B_Wr,
   input  logic [AW-1:0]    i_B_Addr,
   input  logic [WIDTH-1:0] i_B_Wr_Data,
   output logic             o_B_Ack,
   output logic             o_B_Rd_DV,
   output logic [WIDTH-1:0] o_B_Rd_Data,
   output logic [AW-1:0]    o_RAM_Addr,
   output logic             o_RAM_Wr_DV,
   output logic [WIDTH-1:0] o_RAM_Wr_Data,
   output logic             o_RAM_Rd_En,
   input  logic             i_RAM_Rd_DV,
   input  logic [WIDTH-1:0] i_RAM_Rd_Data
);

   logic grant_a;
   logic grant_b;

   // Owner tag (1 = B) registered alongside the RAM command, then delayed one
   // more stage to line up with the RAM's one-cycle read return.
   logic cmd_owner_b_reg;
   logic pend_valid_reg;
   logic pend_owner_b_reg;

`ifdef RAM_ARB_FIXED_PRIO_EN
   // Fixed priority: no arbitration history is kept.
`else
   // 1 = A was granted most recently. Reset to 0 so A wins the first tie.
   logic last_a_reg;
`endif

   // ---------------------------------------------------------------------
   // Grant: reset gates both acks so nothing is consumed while in reset.
   // ---------------------------------------------------------------------
   always_comb begin
      grant_a = 1'b0;
      grant_b = 1'b0;
`ifdef RAM_ARB_FIXED_PRIO_EN
      grant_a = i_Rst_L & i_A_Req;
      grant_b = i_Rst_L & i_B_Req & ~i_A_Req;
`else
      grant_a = i_Rst_L & i_A_Req & (~i_B_Req | ~last_a_reg);
      grant_b = i_Rst_L & i_B_Req & (~i_A_Req |  last_a_reg);
`endif
   end

   assign o_A_Ack = grant_a;
   assign o_B_Ack = grant_b;

`ifdef RAM_ARB_FIXED_PRIO_EN
`else
   always_ff @(posedge i_Clk) begin
      if (!i_Rst_L) begin
         last_a_reg <= 1'b0;
      end else if (grant_a) begin
         last_a_reg <= 1'b1;
      end else if (grant_b) begin
         last_a_reg <= 1'b0;
      end
   end
`endif

   // ---------------------------------------------------------------------
   // RAM command stage and read-tag pipeline
   // ---------------------------------------------------------------------
   always_ff @(posedge i_Clk) begin
      if (!i_Rst_L) begin
         o_RAM_Addr       <= '0;
         o_RAM_Wr_DV      <= 1'b0;
         o_RAM_Wr_Data    <= '0;
         o_RAM_Rd_En      <= 1'b0;
         cmd_owner_b_reg  <= 1'b0;
         pend_valid_reg   <= 1'b0;
         pend_owner_b_reg <= 1'b0;
      end else begin
         o_RAM_Wr_DV <= (grant_a & i_A_Wr)  | (grant_b & i_B_Wr);
         o_RAM_Rd_En <= (grant_a & ~i_A_Wr) | (grant_b & ~i_B_Wr);
         if (grant_a) begin
            o_RAM_Addr    <= i_A_Addr;
            o_RAM_Wr_Data <= i_A_Wr_Data;
         end else if (grant_b) begin
            o_RAM_Addr    <= i_B_Addr;
            o_RAM_Wr_Data <= i_B_Wr_Data;
         end
         cmd_owner_b_reg <= grant_b;
         // A read is outstanding at the RAM for exactly the cycle after Rd_En;
         // any return outside that window finds pend_valid_reg low and is dropped.
         pend_valid_reg   <= o_RAM_Rd_En;
         pend_owner_b_reg <= cmd_owner_b_reg;
      end
   end

   // ---------------------------------------------------------------------
   // Per-client read return (client 0 = A, client 1 = B)
   // ---------------------------------------------------------------------
   logic [1:0]       rd_dv;
   logic [WIDTH-1:0] rd_data [2];

   genvar gi;
   for (gi = 0; gi < 2; gi++) begin : g_client
      logic             hit;
      logic             dv_reg;
      logic [WIDTH-1:0] data_reg;

      assign hit = i_RAM_Rd_DV & pend_valid_reg & (pend_owner_b_reg == (gi == 1));

      always_ff @(posedge i_Clk) begin
         if (!i_Rst_L) begin
            dv_reg   <= 1'b0;
            data_reg <= '0;
         end else begin
            dv_reg <= hit;
            // Data holds its last value between pulses.
            if (hit) begin
               data_reg <= i_RAM_Rd_Data;
            end
         end
      end

      assign rd_dv[gi]   = dv_reg;
      assign rd_data[gi] = data_reg;
   end

   assign o_A_Rd_DV   = rd_dv[0];
   assign o_A_Rd_Data = rd_data[0];
   assign o_B_Rd_DV   = rd_dv[1];
   assign o_B_Rd_Data = rd_data[1];

endmodule

// File: tb/tb_ram_1port_arb.sv
// tb_ram_1port_arb
//    Drives ram_1port_arb with directed scenarios followed by random traffic.
//    A behavioural RAM answers the DUT's commands. A reference model tracks
//    the arbitration rule, the memory contents in grant order, and a queue of
//    expected read returns each due three cycles after its grant.
module tb_ram_1port_arb;

   localparam int W  = 8;
   localparam int D  = 256;
   localparam int AW = 8;

   typedef struct packed {
      logic          req;
      logic          wr;
      logic [AW-1:0] addr;
      logic [W-1:0]  data;
   } cli_t;

   typedef struct {
      bit           is_b;
      logic [W-1:0] data;
      int           due;
   } rd_exp_t;

   logic          clk = 1'b0;
   logic          rst_l = 1'b0;
   logic          a_req = 1'b0, a_wr = 1'b0, b_req = 1'b0, b_wr = 1'b0;
   logic [AW-1:0] a_addr = '0, b_addr = '0;
   logic [W-1:0]  a_wd = '0, b_wd = '0;
   logic          a_ack, b_ack, a_rd_dv, b_rd_dv;
   logic [W-1:0]  a_rd_data, b_rd_data;
   logic [AW-1:0] ram_addr;
   logic          ram_wr_dv, ram_rd_en;
   logic [W-1:0]  ram_wr_data;
   logic          ram_rd_dv;
   logic [W-1:0]  ram_rd_data;

   // Behavioural single-port RAM, one-cycle read latency, plus spurious injection.
   logic [W-1:0]  mem [D];
   logic          ram_dv_reg = 1'b0;
   logic [W-1:0]  ram_q_reg = '0;
   logic          spur_dv = 1'b0;
   logic [W-1:0]  spur_data = '0;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      ram_dv_reg <= ram_rd_en;
      if (ram_rd_en) ram_q_reg <= mem[ram_addr];
      if (ram_wr_dv) mem[ram_addr] <= ram_wr_data;
   end

   assign ram_rd_dv   = ram_dv_reg | spur_dv;
   assign ram_rd_data = ram_dv_reg ? ram_q_reg : spur_data;

   ram_1port_arb #(.WIDTH(W), .DEPTH(D)) dut (
      .i_Clk(clk), .i_Rst_L(rst_l),
      .i_A_Req(a_req), .i_A_Wr(a_wr), .i_A_Addr(a_addr), .i_A_Wr_Data(a_wd),
      .o_A_Ack(a_ack), .o_A_Rd_DV(a_rd_dv), .o_A_Rd_Data(a_rd_data),
      .i_B_Req(b_req), .i_B_Wr(b_wr), .i_B_Addr(b_addr), .i_B_Wr_Data(b_wd),
      .o_B_Ack(b_ack), .o_B_Rd_DV(b_rd_dv), .o_B_Rd_Data(b_rd_data),
      .o_RAM_Addr(ram_addr), .o_RAM_Wr_DV(ram_wr_dv), .o_RAM_Wr_Data(ram_wr_data),
      .o_RAM_Rd_En(ram_rd_en), .i_RAM_Rd_DV(ram_rd_dv), .i_RAM_Rd_Data(ram_rd_data)
   );

   // ------------------------------------------------------------------
   // Reference model state
   // ------------------------------------------------------------------
   int            n_chk = 0;
   int            n_err = 0;
   int            cyc = 0;
   logic [W-1:0]  ref_mem [D];
   rd_exp_t       exp_q [$];
   bit            last_was_b = 1'b1;
   logic          exp_wr = 1'b0, exp_rd = 1'b0;
   logic [AW-1:0] exp_addr = '0;
   logic [W-1:0]  exp_wd = '0;
   logic [W-1:0]  hold_a = '0, hold_b = '0;
   int            obs_ack_a = 0, obs_ack_b = 0, obs_wr = 0, obs_dv_a = 0, obs_dv_b = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, got, exp);
      end
   endtask

   // One clock cycle: drive, check everything visible this cycle, advance model.
   task automatic step(input cli_t a, input cli_t b, input logic rst_in, input logic spur,
                       output logic ea, output logic eb);
      logic da, db;
      rd_exp_t e;
      cli_t c;
      @(negedge clk);
      rst_l = rst_in;
      a_req = a.req; a_wr = a.wr; a_addr = a.addr; a_wd = a.data;
      b_req = b.req; b_wr = b.wr; b_addr = b.addr; b_wd = b.data;
      spur_dv = spur; spur_data = 8'($urandom);
      #1;
      ea = 1'b0; eb = 1'b0;
      if (rst_in) begin
         if (a.req && b.req) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
            ea = 1'b1;
`else
            ea = last_was_b;
            eb = !last_was_b;
`endif
         end else begin
            ea = a.req;
            eb = b.req;
         end
      end
      check_val("ack_a", a_ack, ea);
      check_val("ack_b", b_ack, eb);
      check_val("ram_wr_dv", ram_wr_dv, exp_wr);
      check_val("ram_rd_en", ram_rd_en, exp_rd);
      if (exp_wr || exp_rd) check_val("ram_addr", ram_addr, exp_addr);
      if (exp_wr) check_val("ram_wr_data", ram_wr_data, exp_wd);

      da = 1'b0; db = 1'b0;
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
         e = exp_q.pop_front();
         if (e.is_b) begin db = 1'b1; hold_b = e.data; end
         else        begin da = 1'b1; hold_a = e.data; end
      end
      check_val("rd_dv_a", a_rd_dv, da);
      check_val("rd_dv_b", b_rd_dv, db);
      check_val("rd_data_a", a_rd_data, hold_a);
      check_val("rd_data_b", b_rd_data, hold_b);

      if (a_ack === 1'b1) obs_ack_a++;
      if (b_ack === 1'b1) obs_ack_b++;
      if (ram_wr_dv === 1'b1) obs_wr++;
      if (a_rd_dv === 1'b1) obs_dv_a++;
      if (b_rd_dv === 1'b1) obs_dv_b++;

      if (!rst_in) begin
         exp_q.delete();
         last_was_b = 1'b1;
         exp_wr = 1'b0; exp_rd = 1'b0;
         exp_addr = '0; exp_wd = '0;
         hold_a = '0; hold_b = '0;
      end else if (ea || eb) begin
         c = ea ? a : b;
         exp_wr = c.wr; exp_rd = !c.wr;
         exp_addr = c.addr;
         exp_wd = c.data;
         if (c.wr) ref_mem[c.addr] = c.data;
         else exp_q.push_back('{is_b: eb, data: ref_mem[c.addr], due: cyc + 3});
         last_was_b = eb;
      end else begin
         exp_wr = 1'b0; exp_rd = 1'b0;
      end
      @(posedge clk);
      cyc++;
   endtask

   function automatic cli_t mk(input logic wr, input logic [AW-1:0] addr, input logic [W-1:0] data);
      cli_t c;
      c.req = 1'b1; c.wr = wr; c.addr = addr; c.data = data;
      return c;
   endfunction

   task automatic clear_counts();
      obs_ack_a = 0; obs_ack_b = 0; obs_wr = 0; obs_dv_a = 0; obs_dv_b = 0;
   endtask

   cli_t idle = '0;
   logic xa, xb;

   initial begin
      for (int i = 0; i < D; i++) begin
         mem[i] = '0;
         ref_mem[i] = '0;
      end
      // Bring registers out of X before any comparison.
      rst_l = 1'b0;
      repeat (2) @(posedge clk);

      // Reset state is checked by the first step.
      step(idle, idle, 1'b0, 1'b0, xa, xb);

      // A writes 0x11..0x14 back-to-back, B idle.
      clear_counts();
      for (int i = 0; i < 4; i++) step(mk(1'b1, 8'(i), 8'(8'h11 + i)), idle, 1'b1, 1'b0, xa, xb);
      step(idle, idle, 1'b1, 1'b0, xa, xb);
      check_val("burst_ack_a", obs_ack_a, 4);
      check_val("burst_wr_dv", obs_wr, 4);

      // Reset so arbitration starts from a tie where A wins.
      step(idle, idle, 1'b0, 1'b0, xa, xb);
      step(idle, idle, 1'b1, 1'b0, xa, xb);

      // Both clients read every cycle for four cycles.
      clear_counts();
      for (int i = 0; i < 4; i++) step(mk(1'b0, 8'd0, 8'd0), mk(1'b0, 8'd3, 8'd0), 1'b1, 1'b0, xa, xb);
`ifdef RAM_ARB_FIXED_PRIO_EN
      check_val("contend_ack_a", obs_ack_a, 4);
      check_val("contend_ack_b", obs_ack_b, 0);
`else
      check_val("contend_ack_a", obs_ack_a, 2);
      check_val("contend_ack_b", obs_ack_b, 2);
`endif
      step(idle, mk(1'b0, 8'd3, 8'd0), 1'b1, 1'b0, xa, xb);
      check_val("b_after_a_drop", xb, 1);
      repeat (4) step(idle, idle, 1'b1, 1'b0, xa, xb);
      check_val("contend_data_a", a_rd_data, 8'h11);
      check_val("contend_data_b", b_rd_data, 8'h14);

      // B write then read of the same address.
      step(idle, mk(1'b1, 8'd2, 8'h55), 1'b1, 1'b0, xa, xb);
      step(idle, mk(1'b0, 8'd2, 8'h00), 1'b1, 1'b0, xa, xb);
      repeat (4) step(idle, idle, 1'b1, 1'b0, xa, xb);
      check_val("wr_rd_b_data", b_rd_data, 8'h55);

      // Reset one cycle after an A read is acked: that read never returns.
      clear_counts();
      step(mk(1'b0, 8'd1, 8'd0), idle, 1'b1, 1'b0, xa, xb);
      step(idle, idle, 1'b0, 1'b0, xa, xb);
      repeat (4) step(idle, idle, 1'b1, 1'b0, xa, xb);
      check_val("rst_drop_dv_a", obs_dv_a, 0);
      step(mk(1'b0, 8'd1, 8'd0), idle, 1'b1, 1'b0, xa, xb);
      check_val("reread_ack_a", xa, 1);
      repeat (4) step(idle, idle, 1'b1, 1'b0, xa, xb);
      check_val("reread_dv_a", obs_dv_a, 1);
      check_val("reread_data_a", a_rd_data, 8'h12);

      // Spurious RAM return with nothing outstanding.
      clear_counts();
      step(idle, idle, 1'b1, 1'b1, xa, xb);
      repeat (3) step(idle, idle, 1'b1, 1'b0, xa, xb);
      check_val("spur_dv", obs_dv_a + obs_dv_b, 0);

      // Random traffic: requests held until acked, occasional drops and resets.
      begin
         cli_t ra, rb;
         int   quiet;
         logic rst_now, spur_now;
         ra = '0; rb = '0; quiet = 0;
         for (int i = 0; i < 600; i++) begin
            rst_now = ($urandom_range(0, 99) != 0);
            if (!rst_now || quiet > 0) begin
               ra = '0; rb = '0;
            end else begin
               if (!ra.req && $urandom_range(0, 1) == 1) ra = mk(1'($urandom_range(0, 1)), 8'($urandom_range(0, 7)), 8'($urandom));
               else if (ra.req && $urandom_range(0, 19) == 0) ra = '0;
               if (!rb.req && $urandom_range(0, 1) == 1) rb = mk(1'($urandom_range(0, 1)), 8'($urandom_range(0, 7)), 8'($urandom));
               else if (rb.req && $urandom_range(0, 19) == 0) rb = '0;
            end
            spur_now = (exp_q.size() == 0) && ($urandom_range(0, 9) == 0);
            step(ra, rb, rst_now, spur_now, xa, xb);
            if (xa) ra = '0;
            if (xb) rb = '0;
            if (!rst_now) quiet = 1;
            else if (quiet > 0) quiet--;
         end
         repeat (4) step(idle, idle, 1'b1, 1'b0, xa, xb);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
